// File: rtl/divmmc_mapper_if.sv
// -----------------------------------------------------------------------------
// divmmc_mapper_if
//   Z80 bus as seen by the divMMC mapper.
//   Signals (all driven by the CPU side):
//     mreq, iorq, wr, m1 : Z80 strobes, active-low
//     a                  : CPU address
//     d                  : CPU data out
//   Modports:
//     master : CPU / bench side, drives everything
//     slave  : mapper side, samples everything
//   Bus contract: strobes are level-qualified; the mapper samples them on
//   every clock edge where its clock enable is high, and there is no
//   back-pressure (no ready signal). One qualified edge equals one bus cycle.
// -----------------------------------------------------------------------------
interface divmmc_mapper_if;
    logic        mreq;
    logic        iorq;
    logic        wr;
    logic        m1;
    logic [15:0] a;
    logic [7:0]  d;

    modport master (output mreq, output iorq, output wr, output m1,
                    output a, output d);
    modport slave  (input mreq, input iorq, input wr, input m1,
                    input a, input d);
endinterface

// File: rtl/divmmc_mapper.sv
// -----------------------------------------------------------------------------
// divmmc_mapper
//   divMMC memory mapper: overlays divMMC ROM/RAM on 0000h-3FFFh either on
//   command (conmem, port E3h) or automatically on opcode-fetch traps.
//   Also generates the CPU NMI from a debounced-elsewhere button.
//   Parameters:
//     PAGE_BITS       : RAM bank select width (4..6)
//     NMI_TRAP_ALWAYS : 1 = 0066h trap fires without a pending NMI
//     ROM_TRAPS       : 1 = enable 04C6h / 0562h tape traps
//   Ports:
//     clock, reset    : clock, asynchronous active-low reset
//     ce              : CPU clock enable, qualifies every state update
//     enable          : automapper enable (does not affect conmem or NMI)
//     bus             : Z80 bus (mreq, iorq, wr, m1, a, d)
//     nmi_button      : asynchronous NMI request, active-high
//     eprom_wr        : ROM bank writable jumper
//     map             : overlay active
//     rom_cs, ram_cs  : divMMC ROM / RAM selected for the current access
//     we_ok           : current overlay access may be written
//     page            : RAM bank for the current access
//     nmi_n           : NMI to CPU, active-low
// -----------------------------------------------------------------------------
module divmmc_mapper #(
    parameter int PAGE_BITS       = 4,
    parameter bit NMI_TRAP_ALWAYS = 1'b0,
    parameter bit ROM_TRAPS       = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 enable,
    divmmc_mapper_if.slave       bus,
    input  logic                 nmi_button,
    input  logic                 eprom_wr,
    output logic                 map,
    output logic                 rom_cs,
    output logic                 ram_cs,
    output logic                 we_ok,
    output logic [PAGE_BITS-1:0] page,
    output logic                 nmi_n
);

    localparam logic [PAGE_BITS-1:0] BANK3 = PAGE_BITS'(3);

    logic                 conmem_q,   conmem_d;
    logic                 mapram_q,   mapram_d;
    logic [PAGE_BITS-1:0] bank_q,     bank_d;
    logic                 automap_q,  automap_d;
    logic                 armed_q,    armed_d;
    logic                 nmi_pend_q, nmi_pend_d;
    // [0],[1] synchronise the button, [2] holds the previous synced level
    logic [2:0]           nmi_sync_q, nmi_sync_d;

    logic is_fetch;
    logic is_mem_nm1;
    logic is_port_wr;
    logic trap_delayed;
    logic trap_exit;
    logic trap_imm;
    logic nmi_edge;
    logic at_0066;

    // Upper data bits are unused for narrow bank widths.
    logic unused_d_bits;
    assign unused_d_bits = ^bus.d;

    // Cycle classification (ce is applied in the register block).
    assign is_fetch   = !bus.mreq && !bus.m1;
    assign is_mem_nm1 = !bus.mreq &&  bus.m1;
    assign is_port_wr = !bus.iorq && !bus.wr && (bus.a[7:0] == 8'hE3);

    assign at_0066 = (bus.a == 16'h0066);

    assign trap_delayed = (bus.a == 16'h0000) || (bus.a == 16'h0008) ||
                          (bus.a == 16'h0038) ||
                          (ROM_TRAPS && ((bus.a == 16'h04C6) || (bus.a == 16'h0562))) ||
                          (at_0066 && (nmi_pend_q || NMI_TRAP_ALWAYS));
    assign trap_exit    = (bus.a[15:3] == 13'h03FF);   // 1FF8h-1FFFh
    assign trap_imm     = (bus.a[15:8] == 8'h3D);      // 3D00h-3DFFh

    assign nmi_edge = nmi_sync_q[1] && !nmi_sync_q[2];

    always_comb begin
        conmem_d   = conmem_q;
        mapram_d   = mapram_q;
        bank_d     = bank_q;
        automap_d  = automap_q;
        armed_d    = armed_q;
        nmi_pend_d = nmi_pend_q;
        nmi_sync_d = {nmi_sync_q[1], nmi_sync_q[0], nmi_button};

        // Port write is independent of trap handling; both may act at once.
        if (is_port_wr) begin
            conmem_d = bus.d[7];
            mapram_d = bus.d[6] | mapram_q;   // sticky until reset
            bank_d   = bus.d[PAGE_BITS-1:0];
        end

        if (is_fetch) begin
            if (trap_delayed) begin
                armed_d = 1'b1;
            end else if (trap_exit) begin
                // automap is left alone so the exit routine keeps running
                // from the overlay until the next non-M1 memory cycle.
                armed_d = 1'b0;
            end else if (trap_imm) begin
                armed_d   = 1'b1;
                automap_d = 1'b1;
            end
        end else if (is_mem_nm1) begin
            automap_d = armed_q;
        end

        // Clearing on the 0066h fetch takes precedence over a new edge.
        if (is_fetch && at_0066) begin
            nmi_pend_d = 1'b0;
        end else if (nmi_edge) begin
            nmi_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conmem_q   <= 1'b0;
            mapram_q   <= 1'b0;
            bank_q     <= '0;
            automap_q  <= 1'b0;
            armed_q    <= 1'b0;
            nmi_pend_q <= 1'b0;
            nmi_sync_q <= '0;
        end else if (ce) begin
            conmem_q   <= conmem_d;
            mapram_q   <= mapram_d;
            bank_q     <= bank_d;
            automap_q  <= automap_d;
            armed_q    <= armed_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_sync_q <= nmi_sync_d;
        end
    end

    assign map   = conmem_q | (automap_q & enable);
    assign nmi_n = !nmi_pend_q;

    // Address decode for the overlay window.
    always_comb begin
        rom_cs = 1'b0;
        ram_cs = 1'b0;
        we_ok  = 1'b0;
        page   = bank_q;
        if (map && (bus.a[15:14] == 2'b00)) begin
            if (!bus.a[13]) begin
                if (conmem_q || !mapram_q) begin
                    rom_cs = 1'b1;
                    we_ok  = eprom_wr;
                end else begin
                    // mapram: bank 3 stands in for the ROM, read-only
                    ram_cs = 1'b1;
                    page   = BANK3;
                end
            end else begin
                ram_cs = 1'b1;
                we_ok  = !(mapram_q && !conmem_q && (bank_q == BANK3));
            end
        end
    end

endmodule

// File: tb/tb_divmmc_mapper.sv
module tb_divmmc_mapper;

  localparam int K_IDLE  = 0;
  localparam int K_FETCH = 1;
  localparam int K_READ  = 2;
  localparam int K_WRITE = 3;
  localparam int K_OUT   = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ce = 1'b1;
  logic enable = 1'b1;
  logic nmi_button = 1'b0;
  logic eprom_wr = 1'b1;

  always #5 clock = ~clock;

  divmmc_mapper_if bus();

  logic       map0, rom0, ram0, we0, nmi_n0;
  logic [3:0] page0;
  logic       map1, rom1, ram1, we1, nmi_n1;
  logic [5:0] page1;

  divmmc_mapper u_dut0 (
    .clock(clock), .reset(reset), .ce(ce), .enable(enable), .bus(bus.slave),
    .nmi_button(nmi_button), .eprom_wr(eprom_wr),
    .map(map0), .rom_cs(rom0), .ram_cs(ram0), .we_ok(we0), .page(page0),
    .nmi_n(nmi_n0)
  );

  divmmc_mapper #(.PAGE_BITS(6)) u_dut1 (
    .clock(clock), .reset(reset), .ce(ce), .enable(enable), .bus(bus.slave),
    .nmi_button(nmi_button), .eprom_wr(eprom_wr),
    .map(map1), .rom_cs(rom1), .ram_cs(ram1), .we_ok(we1), .page(page1),
    .nmi_n(nmi_n1)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_bus(input int kind, input logic [15:0] addr, input logic [7:0] data);
    bus.mreq = 1'b1; bus.iorq = 1'b1; bus.wr = 1'b1; bus.m1 = 1'b1;
    bus.a = addr; bus.d = data;
    case (kind)
      K_FETCH: begin bus.mreq = 1'b0; bus.m1 = 1'b0; end
      K_READ:  bus.mreq = 1'b0;
      K_WRITE: begin bus.mreq = 1'b0; bus.wr = 1'b0; end
      K_OUT:   begin bus.iorq = 1'b0; bus.wr = 1'b0; end
      default: ;
    endcase
  endtask

  // Present one bus cycle, clock it, sample 1 time unit after the edge.
  task automatic step(input int kind, input logic [15:0] addr, input logic [7:0] data);
    set_bus(kind, addr, data);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic check_dec0(input string name, input logic [3:0] exp, input logic [3:0] pg);
    check({name, ".map_rom_ram_we"}, {28'd0, map0, rom0, ram0, we0}, {28'd0, exp});
    check({name, ".page"}, {28'd0, page0}, {28'd0, pg});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [7:0]  d;
    logic        en;
    logic [3:0]  exp;   // {map, rom_cs, ram_cs, we_ok}
    logic [3:0]  pg;
  } vec_t;

  vec_t vecs[19];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic got;

    vecs[0]  = '{K_READ,  16'h0000, 8'h00, 1'b1, 4'b0000, 4'h0};
    vecs[1]  = '{K_FETCH, 16'h0038, 8'h00, 1'b1, 4'b0000, 4'h0};
    vecs[2]  = '{K_READ,  16'h1234, 8'h00, 1'b1, 4'b1101, 4'h0};
    vecs[3]  = '{K_FETCH, 16'h1000, 8'h00, 1'b1, 4'b1101, 4'h0};
    vecs[4]  = '{K_READ,  16'h8000, 8'h00, 1'b1, 4'b1000, 4'h0};
    vecs[5]  = '{K_FETCH, 16'h1FFA, 8'h00, 1'b1, 4'b1101, 4'h0};
    vecs[6]  = '{K_READ,  16'h0100, 8'h00, 1'b1, 4'b0000, 4'h0};
    vecs[7]  = '{K_FETCH, 16'h3D2F, 8'h00, 1'b1, 4'b1011, 4'h0};
    vecs[8]  = '{K_READ,  16'h3D30, 8'h00, 1'b1, 4'b1011, 4'h0};
    vecs[9]  = '{K_IDLE,  16'h0000, 8'h00, 1'b0, 4'b0000, 4'h0};
    vecs[10] = '{K_IDLE,  16'h0000, 8'h00, 1'b1, 4'b1101, 4'h0};
    vecs[11] = '{K_OUT,   16'h00E3, 8'h43, 1'b1, 4'b1010, 4'h3};
    vecs[12] = '{K_OUT,   16'h00E3, 8'h03, 1'b1, 4'b1010, 4'h3};
    vecs[13] = '{K_READ,  16'h0100, 8'h00, 1'b1, 4'b1010, 4'h3};
    vecs[14] = '{K_WRITE, 16'h2000, 8'h00, 1'b1, 4'b1010, 4'h3};
    vecs[15] = '{K_OUT,   16'h00E3, 8'h05, 1'b1, 4'b1010, 4'h3};
    vecs[16] = '{K_READ,  16'h2000, 8'h00, 1'b1, 4'b1011, 4'h5};
    vecs[17] = '{K_OUT,   16'h00E3, 8'h80, 1'b1, 4'b1101, 4'h0};
    vecs[18] = '{K_FETCH, 16'h0562, 8'h00, 1'b1, 4'b1101, 4'h0};

    // reset values, asynchronous (no clock edge yet)
    set_bus(K_FETCH, 16'h0000, 8'h00);
    #1;
    check_dec0("reset_dut0", 4'b0000, 4'h0);
    check("reset_dut0.nmi_n", {31'd0, nmi_n0}, 32'd1);
    check("reset_dut1.map_rom_ram_we", {28'd0, map1, rom1, ram1, we1}, 32'd0);
    check("reset_dut1.page", {26'd0, page1}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // main table
    for (int i = 0; i < 19; i++) begin
      enable = vecs[i].en;
      step(vecs[i].kind, vecs[i].a, vecs[i].d);
      check_dec0($sformatf("vec%0d", i), vecs[i].exp, vecs[i].pg);
    end
    enable = 1'b1;

    // immediate-map window boundaries
    do_reset();
    step(K_FETCH, 16'h3CFF, 8'h00);
    check("imm_below_3d00.map", {31'd0, map0}, 32'd0);
    step(K_FETCH, 16'h3DFF, 8'h00);
    check("imm_at_3dff.map", {31'd0, map0}, 32'd1);

    // NMI: no pending -> 0066h does not arm
    do_reset();
    step(K_FETCH, 16'h0066, 8'h00);
    step(K_READ, 16'h0100, 8'h00);
    check("nmi_trap_no_pend.map", {31'd0, map0}, 32'd0);

    // pulse: nmi_n low within 3 ce cycles
    nmi_button = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(K_IDLE, 16'h0000, 8'h00);
      nmi_button = 1'b0;
      if (!nmi_n0) begin
        got = 1'b1;
        break;
      end
    end
    check("nmi_latency", {31'd0, got}, 32'd1);

    // second pulse while pending is dropped
    nmi_button = 1'b1;
    step(K_IDLE, 16'h0000, 8'h00);
    nmi_button = 1'b0;
    repeat (4) step(K_IDLE, 16'h0000, 8'h00);
    check("nmi_held.nmi_n", {31'd0, nmi_n0}, 32'd0);
    step(K_FETCH, 16'h0066, 8'h00);
    check("nmi_clear.nmi_n", {31'd0, nmi_n0}, 32'd1);
    check("nmi_fetch.map", {31'd0, map0}, 32'd0);
    step(K_READ, 16'h0100, 8'h00);
    check("nmi_trap_armed.map", {31'd0, map0}, 32'd1);
    repeat (4) step(K_IDLE, 16'h0000, 8'h00);
    check("nmi_second_ignored.nmi_n", {31'd0, nmi_n0}, 32'd1);
    step(K_FETCH, 16'h1FF8, 8'h00);
    check("exit_fetch.map", {31'd0, map0}, 32'd1);
    step(K_READ, 16'h0100, 8'h00);
    check("exit_read.map", {31'd0, map0}, 32'd0);

    // ce=0 freezes everything including the synchroniser
    ce = 1'b0;
    step(K_FETCH, 16'h3D00, 8'h00);
    check("ce_freeze_fetch.map", {31'd0, map0}, 32'd0);
    step(K_OUT, 16'h00E3, 8'h80);
    check("ce_freeze_out.map", {31'd0, map0}, 32'd0);
    nmi_button = 1'b1;
    repeat (3) step(K_IDLE, 16'h0000, 8'h00);
    nmi_button = 1'b0;
    ce = 1'b1;
    repeat (4) step(K_IDLE, 16'h0000, 8'h00);
    check("ce_freeze_sync.nmi_n", {31'd0, nmi_n0}, 32'd1);
    step(K_FETCH, 16'h3D00, 8'h00);
    check("ce_resume_imm.map", {31'd0, map0}, 32'd1);

    // PAGE_BITS=6 instance: conmem overrides enable=0
    do_reset();
    enable = 1'b0;
    step(K_OUT, 16'h00E3, 8'hA5);
    check("pb6_conmem.map", {31'd0, map1}, 32'd1);
    step(K_READ, 16'h2000, 8'h00);
    check("pb6_2000.ram_we", {30'd0, ram1, we1}, 32'd3);
    check("pb6_2000.page", {26'd0, page1}, 32'h25);
    eprom_wr = 1'b0;
    step(K_READ, 16'h0000, 8'h00);
    check("pb6_rom.rom_we", {30'd0, rom1, we1}, 32'd2);
    eprom_wr = 1'b1;
    enable = 1'b1;

    // reset mid-activity abandons all state
    do_reset();
    step(K_OUT, 16'h00E3, 8'h40);
    nmi_button = 1'b1;
    step(K_IDLE, 16'h0000, 8'h00);
    nmi_button = 1'b0;
    repeat (3) step(K_IDLE, 16'h0000, 8'h00);
    step(K_FETCH, 16'h0038, 8'h00);
    step(K_READ, 16'h0100, 8'h00);
    check_dec0("pre_reset", 4'b1010, 4'h3);
    check("pre_reset.nmi_n", {31'd0, nmi_n0}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check_dec0("async_reset", 4'b0000, 4'h0);
    check("async_reset.nmi_n", {31'd0, nmi_n0}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    step(K_READ, 16'h0100, 8'h00);
    check("post_reset_read.map", {31'd0, map0}, 32'd0);
    step(K_FETCH, 16'h3D00, 8'h00);
    step(K_READ, 16'h0100, 8'h00);
    check_dec0("post_reset_mapram_clear", 4'b1101, 4'h0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
